muldiv_unit: RTL and testbench

Iterative, parametrised RV32M multiply/divide unit for the next-generation core. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over WIDTH-bit operands with a start/busy/done handshake and a fixed multicycle latency. It sits beside the single-cycle ALU in the datapath, and the controller stalls the PC while `busy` is high. RISC-V divide-by-zero and signed-overflow results are produced in hardware.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring shift-subtract divide over WIDTH
//               cycles, followed by a sign/special-case fix-up cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              c_CW   = $clog2(WIDTH) + 1;
  localparam logic [1:0]      c_IDLE = 2'd0;
  localparam logic [1:0]      c_CALC = 2'd1;
  localparam logic [1:0]      c_FIX  = 2'd2;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [c_CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, a_q, a_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, divz_q, divz_d, ovf_q, ovf_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode at accept: signedness depends on the opcode
  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_a_neg    = w_a_signed & a[WIDTH-1];
  assign w_b_neg    = w_b_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;

  // One multiply step: conditionally add multiplicand into the high half, shift right
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // One divide step: shift {rem,quo} left, subtract divisor when it fits
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, mb_q};
  assign w_ge       = (w_rem_sh >= {1'b0, mb_q});
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], w_ge};

  // Final result selection with sign correction and RISC-V special cases
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_fix_result;
  assign w_prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign w_quo  = acc_q[WIDTH-1:0];
  assign w_rem  = acc_q[2*WIDTH-1:WIDTH];

  // Pick the architectural result for the latched opcode
  always_comb begin
    w_fix_result = '0;
    case (op_q)
      3'b000:                 w_fix_result = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: begin
        if (divz_q)          w_fix_result = '1;
        else if (ovf_q)      w_fix_result = a_q;
        else if (sa_q ^ sb_q) w_fix_result = -w_quo;
        else                 w_fix_result = w_quo;
      end
      default: begin
        if (divz_q)     w_fix_result = a_q;
        else if (ovf_q) w_fix_result = '0;
        else if (sa_q)  w_fix_result = -w_rem;
        else            w_fix_result = w_rem;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = c_CALC;
      c_CALC:  if (cnt_q == c_LAST) state_d = c_FIX;
      c_FIX:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM handshake outputs (registered below)
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      c_IDLE: if (start) busy_d = 1'b1;
      c_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch operands at accept, iterate in CALC, finish in FIX
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    a_d      = a_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    divz_d   = divz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      c_IDLE: if (start) begin
        cnt_d  = '0;
        op_d   = op;
        a_d    = a;
        ma_d   = w_a_mag;
        mb_d   = w_b_mag;
        sa_d   = w_a_neg;
        sb_d   = w_b_neg;
        divz_d = (b == '0);
        ovf_d  = op[2] & ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
        // Multiply keeps the multiplier in the low half; divide keeps the dividend there
        acc_d  = {{WIDTH{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
      end
      c_CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = op_q[2] ? w_div_next : w_mul_next;
      end
      c_FIX:   result_d = w_fix_result;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      a_q      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      a_q      <= a_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit at WIDTH=32
//               and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        s8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(s32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; counts cycles until done, bounded
  task automatic wait_done32(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy32 ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
      if (busy32) bcnt++;
    end
  endtask

  task automatic wait_done8(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy8 ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
      if (busy8) bcnt++;
    end
  endtask

  task automatic run32(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    int lat, bc;
    @(posedge clk); #1;
    op32 = o; a32 = x; b32 = y; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0; op32 = ~o; a32 = ~x; b32 = ~y;
    wait_done32(lat, bc);
    check({tag, "/result"}, res32, exp);
    check({tag, "/latency"}, lat, 33);
    check({tag, "/busy_cycles"}, bc, 33);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, {31'd0, done32}, 32'd0);
    check({tag, "/held"}, res32, exp);
  endtask

  task automatic run8(input string tag, input logic [2:0] o,
                      input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp);
    int lat, bc;
    @(posedge clk); #1;
    op8 = o; a8 = x; b8 = y; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0; op8 = ~o; a8 = ~x; b8 = ~y;
    wait_done8(lat, bc);
    check({tag, "/result"}, {24'd0, res8}, {24'd0, exp});
    check({tag, "/latency"}, lat, 9);
    check({tag, "/busy_cycles"}, bc, 9);
  endtask

  initial begin
    int lat, bc, ndone, nbusy;
    reset = 1'b1;
    s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy32",   {31'd0, busy32}, 32'd0);
    check("reset/done32",   {31'd0, done32}, 32'd0);
    check("reset/result32", res32, 32'd0);
    check("reset/result8",  {24'd0, res8}, 32'd0);
    reset = 1'b0;

    // Multiply
    run32("MUL_7x6",      3'b000, 32'd7,        32'd6,        32'h0000002A);
    run32("MULH_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run32("MULHU_ones",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run32("MULHSU_ones",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run32("MUL_neg1x3",   3'b000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD);
    // Divide
    run32("DIV_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run32("REM_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run32("DIVU_100_7",   3'b101, 32'd100,      32'd7,        32'd14);
    run32("REMU_100_7",   3'b111, 32'd100,      32'd7,        32'd2);
    run32("REM_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1);
    // Special cases
    run32("DIV_5_0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF);
    run32("REMU_5_0",     3'b111, 32'd5,        32'd0,        32'd5);
    run32("DIV_m5_0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    run32("REM_m5_0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    run32("DIV_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run32("REM_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // start while busy is ignored
    @(posedge clk); #1;
    op32 = 3'b000; a32 = 32'd3; b32 = 32'd4; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op32 = 3'b000; a32 = 32'd9; b32 = 32'd9; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    wait_done32(lat, bc);
    check("ignore/result",  res32, 32'd12);
    check("ignore/latency", lat + 5, 33);

    // back-to-back: start raised in the done cycle
    @(posedge clk); #1;
    op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    wait_done32(lat, bc);
    check("b2b/first", res32, 32'd14);
    op32 = 3'b111; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    check("b2b/accepted", {31'd0, busy32}, 32'd1);
    wait_done32(lat, bc);
    check("b2b/second",  res32, 32'd2);
    check("b2b/latency", lat, 33);

    // reset mid-operation aborts without done
    @(posedge clk); #1;
    op32 = 3'b000; a32 = 32'd5; b32 = 32'd5; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort/busy",   {31'd0, busy32}, 32'd0);
    check("abort/result", res32, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32) ndone++;
      if (busy32) nbusy++;
    end
    check("abort/no_done", ndone, 0);
    check("abort/no_busy", nbusy, 0);

    // WIDTH=8 instance
    run8("W8_MULH",  3'b001, 8'h80, 8'h7F, 8'hC0);
    run8("W8_DIVU",  3'b101, 8'hFF, 8'h10, 8'h0F);
    run8("W8_DIVov", 3'b100, 8'h80, 8'hFF, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
